instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction fetch front end that supplies 32-bit instruction words to the datapath's instruction input, in place of a bench driving them directly.
- Holds the PC and reads instruction memory through a req/ack interface.
- Buffers prefetched words in a small FIFO and hands them to the datapath with a valid/ready handshake.
- Accepts branch redirects, which flush all fetched and in-flight words.

Parameters:
- ADDR_W, 8: byte-address width of PC and mem_addr; PC wraps modulo 2^ADDR_W.
- DEPTH, 2: prefetch FIFO entries (power of two, ≥2).
- RESET_PC, 0: PC value loaded on reset; bits [1:0] ignored.

Ports:
- Clk  input  1  single system clock; all state changes on its rising edge.
- Clr  input  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- mem_req  output  1  memory read request; held until mem_ack.
- mem_addr  output  ADDR_W  byte address of the request; word aligned, stable while mem_req=1 and mem_ack=0.
- mem_ack  input  1  read complete; mem_rdata valid in this cycle.
- mem_rdata  input  32  instruction word returned by memory.
- instruction  output  32  instruction word at FIFO head.
- instr_pc  output  ADDR_W  address of the head word.
- instr_valid  output  1  head word present.
- instr_ready  input  1  datapath accepts head this cycle.
- branch_en  input  1  redirect request (one-cycle pulse).
- branch_target  input  ADDR_W  redirect byte address; bits [1:0] forced to 0.

Behaviour:
- Reset (Clr=0 at an edge):
  - pc=RESET_PC&~3, FIFO empty, no request outstanding, discard=0.
  - Outputs: mem_req=0, mem_addr=RESET_PC&~3, instruction=0, instr_pc=0, instr_valid=0.
  - Reset overrides every other input, including mid-transaction. An outstanding request is abandoned and mem_req drops at that edge; any later mem_ack is ignored while not in FETCH.
- State machine:
  - IDLE: no request outstanding.
  - FETCH: mem_req=1, waiting for mem_ack.
  - DRAIN: mem_req=1, response will be discarded because of a redirect.
- IDLE→FETCH when room>0, where room = DEPTH − fifo_count. mem_req rises in the cycle after the decision; first request appears one cycle after reset release.
- FETCH, mem_ack=1:
  - Push {mem_rdata, mem_addr} into the FIFO.
  - pc = pc+4 (wraps).
  - If room after this cycle's push/pop is >0, stay in FETCH with mem_addr=new pc. This gives back-to-back requests with no bubble.
  - Otherwise go to IDLE.
- FETCH, branch_en=1, no ack: go to DRAIN; pc=branch_target.
- FETCH, branch_en=1 and mem_ack=1 in the same cycle: the returned word is dropped (not pushed); go to FETCH at branch_target.
- DRAIN: mem_addr is held at the old address until mem_ack. The word is dropped, then go to FETCH at pc, or IDLE if there is no room.
- IDLE, branch_en=1: pc=branch_target, then go to FETCH.
- Additional branch_en pulses while in DRAIN update pc only.
- Handshake: the head word is consumed on an edge where instr_valid=1 and instr_ready=1. instruction and instr_pc are held stable while instr_valid=1 and instr_ready=0.
- Latency: a word acked at edge N is visible (instr_valid=1) after edge N, i.e. in cycle N+1. The FIFO has no bypass.
- Simultaneous push and pop is legal at any count, including full. Count stays the same and order is preserved.
- Flush on branch_en:
  - The FIFO is emptied at that edge; instr_valid=0 the next cycle.
  - If pop and branch_en occur together, the pop counts as delivered; all remaining words are flushed.
- Full: no new request issues when fifo_count=DEPTH with nothing popping. The buffer never overflows and no words are lost.
- Empty: instr_valid=0; instruction holds its last value, which is don't-care.
- Ordering: words are delivered in strictly increasing PC order (mod 2^ADDR_W) between redirects. Words fetched before a redirect are never delivered after it.

Test Plan:
- Reset/start-up:
  - Stimulus: Clr=0 for 3 cycles, then 1. Memory returns 03B01001, 03B0A003, 02912003, 00923001 at addresses 00, 04, 08, 0C, with 1-cycle ack and instr_ready=1.
  - Required response: mem_req=0 during reset; first mem_addr=00; datapath receives those four words in order with instr_pc 00, 04, 08, 0C; one word per cycle once streaming.
- Backpressure/full:
  - Stimulus: instr_ready=0 with DEPTH=2.
  - Required response: exactly 2 acks accepted; mem_req stays 0; instruction=03B01001 held stable.
  - Stimulus: then instr_ready=1.
  - Required response: 03B01001 then 03B0A003 delivered; fetch resumes at 08.
- Redirect with response in flight:
  - Stimulus: ack latency 3 cycles; branch_en=1 with target 0x40 while fetching 0x04.
  - Required response: mem_addr stays 0x04 until ack; that word is never delivered; next mem_addr=0x40; next instr_pc=0x40.
- Branch/ack collision and branch/pop collision:
  - Stimulus: branch_en coincides with mem_ack.
  - Required response: acked word dropped.
  - Stimulus: branch_en coincides with a handshake.
  - Required response: head counted delivered; rest flushed; instr_valid=0 next cycle.
- PC wrap:
  - Stimulus: branch to 0xFC (ADDR_W=8), then let fetch continue.
  - Required response: fetch addresses go 0xFC then 0x00.
  - Stimulus: branch_target=0x13.
  - Required response: mem_addr=0x10.
- Reset mid-operation:
  - Stimulus: Clr=0 while mem_req=1 and the FIFO holds 1 word.
  - Required response: next cycle mem_req=0, instr_valid=0; a later stray mem_ack is ignored; refetch begins at 00.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, req/ack instruction-memory fetch, prefetch FIFO and
// valid/ready delivery to the datapath, with branch redirect and flush.
`default_nettype none

module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Clr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_INIT   = {RESET_PC[ADDR_W-1:2], 2'b00};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data [DEPTH];
    logic [ADDR_W-1:0] r_tag  [DEPTH];
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W-1:0]  r_wr;
    logic [CNT_W-1:0]  r_count;

    logic [1:0]        w_state_n;
    logic [ADDR_W-1:0] w_pc_n;
    logic [ADDR_W-1:0] w_addr_n;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_cnt_after_pop;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_unused_tgt_bits;

    assign w_target          = {branch_target[ADDR_W-1:2], 2'b00};
    assign w_unused_tgt_bits = ^branch_target[1:0];
    assign w_pc_inc          = r_pc + ADDR_W'(4);
    assign w_pop             = instr_valid & instr_ready;
    assign w_cnt_after_pop   = r_count - CNT_W'(w_pop);

    // Room is judged after this cycle's pop so a draining full FIFO can
    // start the next fetch without waiting a cycle.
    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_addr_n  = r_addr;
        w_push    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (branch_en) begin
                    w_pc_n    = w_target;
                    w_addr_n  = w_target;
                    w_state_n = S_FETCH;
                end else if (w_cnt_after_pop < CNT_FULL) begin
                    w_addr_n  = r_pc;
                    w_state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                if (branch_en) begin
                    w_pc_n = w_target;
                    if (mem_ack) begin
                        w_addr_n  = w_target;
                        w_state_n = S_FETCH;
                    end else begin
                        w_state_n = S_DRAIN;
                    end
                end else if (mem_ack) begin
                    w_push    = 1'b1;
                    w_pc_n    = w_pc_inc;
                    w_addr_n  = w_pc_inc;
                    w_state_n = (w_cnt_after_pop < CNT_LAST) ? S_FETCH : S_IDLE;
                end
            end
            S_DRAIN: begin
                // mem_addr keeps the abandoned address until memory answers.
                w_pc_n = branch_en ? w_target : r_pc;
                if (mem_ack) begin
                    w_addr_n  = branch_en ? w_target : r_pc;
                    w_state_n = (branch_en || (w_cnt_after_pop < CNT_FULL)) ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clr) begin
            r_state <= S_IDLE;
            r_pc    <= PC_INIT;
            r_addr  <= PC_INIT;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_addr  <= w_addr_n;
            if (branch_en) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_data[r_wr] <= mem_rdata;
                    r_tag[r_wr]  <= r_addr;
                    r_wr         <= r_wr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    assign mem_req     = (r_state != S_IDLE);
    assign mem_addr    = r_addr;
    assign instruction = r_data[r_rd];
    assign instr_pc    = r_tag[r_rd];
    assign instr_valid = (r_count != '0);

endmodule

`default_nettype wire
